fdct_row_sched: RTL and testbench
=================================

// Module: fdct_row_sched
// PURPOSE
// - Sequencer/flow controller for the 8-point 1-D fdct pipeline (4 stages, no stall input).
// - Accepts 8x8 blocks row by row over a valid/ready stream.
// - Issues each accepted row to the datapath and tags it through the pipeline latency.
// - Collects results into an output FIFO and uses credits so in-flight rows are never lost.
// PARAMETERS
// - DW     8   input sample width (bits)
// - OW    11   datapath output coefficient width (bits)
// - LAT    4   datapath latency in clock edges from dct_x update to valid dct_y
// - DEPTH  8   output FIFO entries (power of 2, >= LAT+1)
// PORTS
// - clk      in   1      clock; all state changes on the rising edge
// - reset    in   1      asynchronous, active-high reset
// - s_valid  in   1      input row valid
// - s_ready  out  1      input row accepted when s_valid & s_ready
// - s_row    in   8*DW   8 samples; sample i at [i*DW +: DW]
// - s_last   in   1      marks row 7 of a block
// - dct_x    out  8*DW   row driven to the fdct datapath (registered)
// - dct_y    in   8*OW   datapath result
// - m_valid  out  1      output row valid
// - m_ready  in   1      output row consumed when m_valid & m_ready
// - m_row    out  8*OW   result row
// - m_idx    out  3      row index 0..7 within its block
// - m_last   out  1      high with m_idx==7
// - busy     out  1      block open, row in flight, or FIFO non-empty
// - err_last out  1      1-cycle pulse on an s_last / row-counter mismatch
// BEHAVIOUR
// - Reset values: s_ready=0, dct_x=0, m_valid=0, m_row=0, m_idx=0, m_last=0, busy=0, err_last=0.
// - Reset mid-operation discards all in-flight rows, empties the FIFO and returns the FSM to IDLE.
// - s_ready is 1 the first cycle after reset deasserts.
// - Credits: s_ready = (inflight + fifo_count) < DEPTH, where inflight = popcount of the tag shift register.
//   - s_ready must not depend on s_valid.
// - Accept at edge k:
//   - dct_x <= s_row at edge k.
//   - A tag {valid, idx, last} enters the LAT-deep shift register.
//   - At edge k+LAT+1 the tag exits and {dct_y, idx, last} is pushed into the FIFO.
//   - Minimum accept-to-m_valid latency is LAT+1 edges.
// - dct_x holds its last value when no row is accepted. The datapath still runs; untagged results are ignored.
// - FSM IDLE/FEED:
//   - IDLE -> FEED on an accepted row with idx 0.
//   - FEED -> IDLE on the accept of idx 7.
//   - The row counter increments per accept and wraps 7 -> 0.
// - Mismatch handling:
//   - s_last=1 with counter!=7: pulse err_last, tag the row idx=counter, last=1, reset counter to 0, go to IDLE.
//   - counter==7 with s_last=0: pulse err_last, tag last=1, counter wraps to 0, go to IDLE.
// - FIFO behaviour:
//   - Push and pop in the same edge are legal even when full; occupancy is unchanged.
//   - Pop on empty is impossible (m_valid=0).
//   - Push never meets a full FIFO because of the credit rule.
// - m_valid, m_row, m_idx and m_last are driven from the FIFO head and stay stable while m_valid & !m_ready.
// - Full throughput: one row per cycle sustained when m_ready is held at 1.
// - busy = (state==FEED) | (inflight != 0) | (fifo_count != 0).
// CONFIGURATION
// - Macro FDCT_ROW_SCHED_PERF_EN.
// - Defined: adds outputs perf_blocks[15:0] and perf_stall[15:0].
//   - perf_blocks counts m_last pops.
//   - perf_stall counts cycles with s_valid & !s_ready.
//   - Both counters saturate at 16'hFFFF and clear on reset.
// - Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
// - Package fdct_pkg holds:
//   - DCT_N=8 and DCT_LAT=4 constants.
//   - typedef enum {IDLE, FEED} sched_state_t.
//   - typedef struct packed {logic v; logic [2:0] idx; logic last;} row_tag_t.
// - Sub-module fdct_row_fifo: synchronous FIFO with async active-high reset, width 8*OW+4, DEPTH entries, count output.
// - Tag shift register, credit logic and FSM stay in this module.
// TESTING
// - Reset then 8 back-to-back rows with m_ready=1, first accept at edge 0 -> m_valid rises after edge 5; m_idx 0..7 on consecutive cycles; m_last with idx 7.
// - m_ready=0, 20 rows offered -> exactly 8 accepted; s_ready=0 from then on; then m_ready=1 -> all 8 drain in order with none lost.
// - s_last on row 3 -> err_last pulses once; that row exits with m_last=1, m_idx=3; the next row exits with m_idx=0.
// - Reset asserted with 5 rows in flight and 3 in the FIFO -> m_valid=0, busy=0; no stale row appears after reset.
// - Random s_valid/m_ready at 50% over 1000 blocks -> scoreboard order and idx match; m_row matches the fdct model; no drops.
// - FDCT_ROW_SCHED_PERF_EN defined: 3 blocks plus 10 stall cycles -> perf_blocks=3, perf_stall=10.

Source files
------------

// File: rtl/fdct_pkg.sv
// Shared constants and types for the fdct row scheduler.
package fdct_pkg;

  localparam int DCT_N   = 8;
  localparam int DCT_LAT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
    logic       last;
  } row_tag_t;

endpackage

// File: rtl/fdct_row_fifo.sv
// Synchronous output FIFO for finished rows; register-based storage with
// a combinational head view and an occupancy count.
module fdct_row_fifo #(
  parameter int W     = 92,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          do_pop;

  assign empty  = (count == CW'(0));
  assign do_pop = pop & ~empty;
  assign head   = mem[rd_ptr];

  // Occupancy bookkeeping; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    case ({push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage, pointers and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/fdct_row_sched.sv
// Row sequencer for the 8-point 1-D fdct pipeline: credit-based intake, tag
// tracking through the datapath latency, and an output FIFO.
// Optional counters enabled by defining FDCT_ROW_SCHED_PERF_EN.
module fdct_row_sched
  import fdct_pkg::*;
#(
  parameter int DW    = 8,
  parameter int OW    = 11,
  parameter int LAT   = DCT_LAT,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DCT_N*DW-1:0]   s_row,
  input  logic                  s_last,
  output logic [DCT_N*DW-1:0]   dct_x,
  input  logic [DCT_N*OW-1:0]   dct_y,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DCT_N*OW-1:0]   m_row,
  output logic [2:0]            m_idx,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err_last
`ifdef FDCT_ROW_SCHED_PERF_EN
  ,
  output logic [15:0]           perf_blocks,
  output logic [15:0]           perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = DCT_N * OW + 4;

  sched_state_t  state;
  sched_state_t  state_nxt;
  logic [2:0]    row_cnt;
  logic [2:0]    row_cnt_nxt;
  logic          err_nxt;
  row_tag_t      tag_in;
  // Stage 0 travels with dct_x; the tag reaches stage LAT when dct_y is valid.
  row_tag_t      tag_pipe [LAT+1];

  logic          accept;
  logic          pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [FW-1:0] fifo_head;
  logic [CW-1:0] inflight;
  logic [CW-1:0] total;
  logic [CW-1:0] total_nxt;

  assign accept  = s_valid & s_ready;
  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  assign m_row   = fifo_head[FW-1:4];
  assign m_idx   = fifo_head[3:1];
  assign m_last  = fifo_head[0];

  // Credit accounting: every row in flight or queued holds one FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LAT; i++) inflight = inflight + CW'(tag_pipe[i].v);
    total     = inflight + fifo_count;
    total_nxt = total + CW'(accept) - CW'(pop);
  end

  // Row counter, block FSM and tag generation for the accepted row.
  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    err_nxt     = 1'b0;
    tag_in      = '0;
    if (accept) begin
      tag_in.v    = 1'b1;
      tag_in.idx  = row_cnt;
      tag_in.last = s_last | (row_cnt == 3'd7);
      err_nxt     = s_last ^ (row_cnt == 3'd7);
      if (tag_in.last) begin
        row_cnt_nxt = 3'd0;
        state_nxt   = IDLE;
      end else begin
        row_cnt_nxt = row_cnt + 3'd1;
        case (state)
          IDLE:    state_nxt = FEED;
          FEED:    state_nxt = FEED;
          default: state_nxt = IDLE;
        endcase
      end
    end else begin
      state_nxt   = state;
      row_cnt_nxt = row_cnt;
    end
  end

  // FSM state and row counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      row_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
    end
  end

  // Datapath feed register and tag shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_x <= '0;
      for (int i = 0; i <= LAT; i++) tag_pipe[i] <= '0;
    end else begin
      if (accept) dct_x <= s_row;
      tag_pipe[0] <= accept ? tag_in : row_tag_t'(5'd0);
      for (int i = 1; i <= LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Registered flow-control and status outputs, computed from next-state values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      err_last <= 1'b0;
    end else begin
      s_ready  <= (total_nxt < CW'(DEPTH));
      busy     <= (state_nxt == FEED) | (total_nxt != CW'(0));
      err_last <= err_nxt;
    end
  end

  fdct_row_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_pipe[LAT].v),
    .push_data ({dct_y, tag_pipe[LAT].idx, tag_pipe[LAT].last}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef FDCT_ROW_SCHED_PERF_EN
  // Saturating block and intake-stall counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_blocks <= 16'd0;
      perf_stall  <= 16'd0;
    end else begin
      if (pop & m_last & (perf_blocks != 16'hFFFF)) perf_blocks <= perf_blocks + 16'd1;
      if (s_valid & ~s_ready & (perf_stall != 16'hFFFF)) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fdct_row_sched.sv
// Self-checking bench for fdct_row_sched with a 4-register stand-in datapath.
module tb_fdct_row_sched;

  localparam int DW = 8;
  localparam int OW = 11;

  typedef struct {
    logic [8*OW-1:0] row;
    logic [2:0]      idx;
    logic            last;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_valid;
  logic            s_ready;
  logic [8*DW-1:0] s_row;
  logic            s_last;
  logic [8*DW-1:0] dct_x;
  logic [8*OW-1:0] dct_y;
  logic            m_valid;
  logic            m_ready;
  logic [8*OW-1:0] m_row;
  logic [2:0]      m_idx;
  logic            m_last;
  logic            busy;
  logic            err_last;
`ifdef FDCT_ROW_SCHED_PERF_EN
  logic [15:0]     perf_blocks;
  logic [15:0]     perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  int err_cnt = 0;
  exp_t exp_q[$];
  logic [2:0] out_idx[$];
  logic       out_last[$];
  logic [8*DW-1:0] src_row[$];
  logic            src_last[$];
  logic [2:0] mcnt = 3'd0;
  logic       err_pend = 1'b0;
  logic [8*OW-1:0] dp [4];

  always #5 clk = ~clk;

  fdct_row_sched u_dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_row    (s_row),
    .s_last   (s_last),
    .dct_x    (dct_x),
    .dct_y    (dct_y),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_row    (m_row),
    .m_idx    (m_idx),
    .m_last   (m_last),
    .busy     (busy),
    .err_last (err_last)
`ifdef FDCT_ROW_SCHED_PERF_EN
    ,
    .perf_blocks (perf_blocks),
    .perf_stall  (perf_stall)
`endif
  );

  function automatic logic [8*OW-1:0] fdct_model(input logic [8*DW-1:0] x);
    logic [OW-1:0]   s;
    logic [8*OW-1:0] y;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + OW'(x[i*DW +: DW]);
    y[0 +: OW] = s;
    for (int u = 1; u < 8; u++)
      y[u*OW +: OW] = OW'(x[u*DW +: DW]) * 11'd2 + OW'(x[(8-u)*DW +: DW]);
    return y;
  endfunction

  function automatic logic [8*DW-1:0] mk_row(input int k);
    logic [8*DW-1:0] r;
    for (int j = 0; j < 8; j++) r[j*DW +: DW] = 8'((k * 37 + j * 11 + 5) & 255);
    return r;
  endfunction

  // Stand-in datapath: four registers, so dct_y follows dct_x by four edges.
  always @(posedge clk) begin
    dp[0] <= fdct_model(dct_x);
    dp[1] <= dp[0];
    dp[2] <= dp[1];
    dp[3] <= dp[2];
  end
  assign dct_y = dp[3];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: predicts and checks the handshakes of the coming rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      mcnt     = 3'd0;
      err_pend = 1'b0;
    end else begin
      check("err_last", err_last, err_pend);
      if (err_last) err_cnt++;
      err_pend = 1'b0;
      if (s_valid && s_ready) begin
        e.row    = fdct_model(s_row);
        e.idx    = mcnt;
        e.last   = s_last || (mcnt == 3'd7);
        err_pend = s_last ^ (mcnt == 3'd7);
        mcnt     = e.last ? 3'd0 : mcnt + 3'd1;
        exp_q.push_back(e);
        acc_cnt++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("m_row", m_row, e.row);
          check("m_idx", m_idx, e.idx);
          check("m_last", m_last, e.last);
        end
        out_idx.push_back(m_idx);
        out_last.push_back(m_last);
        out_cnt++;
      end
    end
  end

  task automatic feed(input int max_cyc, input bit rnd, input bit rdy);
    int base;
    int cyc;
    base = acc_cnt;
    cyc  = 0;
    while ((acc_cnt - base) < src_row.size() && cyc < max_cyc) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_row   = src_row[acc_cnt - base];
      s_last  = src_last[acc_cnt - base];
      m_ready = rnd ? 1'($urandom_range(0, 1)) : rdy;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0;
  endtask

  task automatic drain(input int cyc);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (cyc) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_src(input int n, input int seed, input bit rnd);
    src_row.delete();
    src_last.delete();
    for (int k = 0; k < n; k++) begin
      src_row.push_back(rnd ? {$urandom(), $urandom()} : mk_row(seed + k));
      src_last.push_back((k % 8) == 7);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int ob;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_row   = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_dct_x", dct_x, 64'd0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_row", m_row, 88'd0);
    check("rst_m_idx", m_idx, 3'd0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err_last", err_last, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("s_ready_after_rst", s_ready, 1'b1);

    // Back-to-back block: first accept at edge 0, first output after edge 5.
    s_valid = 1'b1;
    s_row   = mk_row(0);
    s_last  = 1'b0;
    m_ready = 1'b1;
    for (int e = 0; e <= 13; e++) begin
      @(posedge clk); #1;
      if (e == 0) begin
        check("t1_dct_x", dct_x, mk_row(0));
        check("t1_busy", busy, 1'b1);
      end
      if (e < 8) check("t1_s_ready", s_ready, 1'b1);
      if (e < 7) begin
        s_row  = mk_row(e + 1);
        s_last = (e + 1 == 7);
      end else begin
        s_valid = 1'b0;
      end
      if (e == 4) check("t1_m_valid_early", m_valid, 1'b0);
      if (e >= 5 && e <= 12) begin
        check("t1_m_valid", m_valid, 1'b1);
        check("t1_m_idx", m_idx, e - 5);
        check("t1_m_last", m_last, e == 12);
      end
      if (e == 13) begin
        check("t1_m_valid_end", m_valid, 1'b0);
        check("t1_busy_end", busy, 1'b0);
      end
    end

    // Output stalled: only DEPTH rows fit, then drain in order.
    load_src(20, 100, 1'b0);
    base = acc_cnt;
    ob   = out_cnt;
    feed(20, 1'b0, 1'b0);
    check("t2_accepted", acc_cnt - base, 8);
    check("t2_s_ready", s_ready, 1'b0);
    check("t2_busy", busy, 1'b1);
    drain(15);
    check("t2_drained", out_cnt - ob, 8);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_m_valid_end", m_valid, 1'b0);

    // Early s_last on row 3, then a block missing its s_last, then a clean block.
    src_row.delete();
    src_last.delete();
    for (int k = 0; k < 20; k++) begin
      src_row.push_back(mk_row(200 + k));
      src_last.push_back(k == 3 || k == 19);
    end
    base = err_cnt;
    ob   = out_idx.size();
    feed(200, 1'b0, 1'b1);
    drain(15);
    check("t3_err_pulses", err_cnt - base, 2);
    check("t3_out_count", out_idx.size() - ob, 20);
    if (out_idx.size() - ob == 20) begin
      check("t3_row3_idx", out_idx[ob+3], 3'd3);
      check("t3_row3_last", out_last[ob+3], 1'b1);
      check("t3_next_idx", out_idx[ob+4], 3'd0);
      check("t3_next_last", out_last[ob+4], 1'b0);
      check("t3_nolast_idx", out_idx[ob+11], 3'd7);
      check("t3_nolast_last", out_last[ob+11], 1'b1);
      check("t3_after_idx", out_idx[ob+12], 3'd0);
    end

    // Reset with five rows in flight and three queued.
    load_src(8, 300, 1'b0);
    base = acc_cnt;
    feed(8, 1'b0, 1'b0);
    check("t4_accepted", acc_cnt - base, 8);
    check("t4_busy_pre", busy, 1'b1);
    check("t4_m_valid_pre", m_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("t4_m_valid_rst", m_valid, 1'b0);
    check("t4_busy_rst", busy, 1'b0);
    check("t4_s_ready_rst", s_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    ob = out_cnt;
    drain(20);
    check("t4_no_stale", out_cnt - ob, 0);
    check("t4_m_valid_post", m_valid, 1'b0);
    check("t4_busy_post", busy, 1'b0);

    // Random handshakes over 1000 blocks.
    load_src(8000, 0, 1'b1);
    base = acc_cnt;
    ob   = out_cnt;
    feed(60000, 1'b1, 1'b0);
    drain(20);
    check("t5_accepted", acc_cnt - base, 8000);
    check("t5_delivered", out_cnt - ob, 8000);
    check("t5_queue_empty", exp_q.size(), 0);

`ifdef FDCT_ROW_SCHED_PERF_EN
    // Three blocks delivered and ten cycles of refused input.
    do_reset();
    load_src(24, 500, 1'b0);
    base = acc_cnt;
    feed(8, 1'b0, 1'b0);
    check("t6_fill", acc_cnt - base, 8);
    s_valid = 1'b1;
    s_row   = src_row[8];
    s_last  = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    drain(12);
    repeat (8) begin
      void'(src_row.pop_front());
      void'(src_last.pop_front());
    end
    feed(100, 1'b0, 1'b1);
    drain(12);
    check("t6_perf_blocks", perf_blocks, 16'd3);
    check("t6_perf_stall", perf_stall, 16'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
